// File: rtl/numpad_digit_loader.sv
// Debounces the numpad encoder's key stream and shifts accepted BCD digits into
// a 4-digit MM:SS entry register, handing it to the timer with a load strobe.
module numpad_digit_loader #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  key_bcd,
  input  logic        key_valid,
  input  logic        enablen,
  input  logic        clearn,
  input  logic        start,
  output logic [15:0] bcd_time,
  output logic [2:0]  entry_count,
  output logic        time_load,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ARM, HELD, RELEASE} state_t;

  localparam logic [2:0] CNT_LAST = 3'(DEBOUNCE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] bcd_q, bcd_d;
  logic [2:0]  count_q, count_d;
  logic        load_q, load_d;
  logic        start_ok, accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      bcd_q   <= '0;
      count_q <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    bcd_d    = bcd_q;
    count_d  = count_q;
    load_d   = 1'b0;
    start_ok = 1'b0;
    accept   = 1'b0;
    if (!clearn) begin
      state_d = IDLE;
      cnt_d   = '0;
      bcd_d   = '0;
      count_d = '0;
    end else if (enablen) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      start_ok = start && (count_q != 3'd0);
      case (state_q)
        IDLE: begin
          if (key_valid && (key_bcd <= 4'd9)) begin
            code_d  = key_bcd;
            cnt_d   = 3'd1;
            state_d = ARM;
          end
        end
        ARM: begin
          if (!key_valid || (key_bcd != code_q)) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            accept  = 1'b1;
            state_d = HELD;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        HELD: begin
          if (!key_valid) begin
            cnt_d   = 3'd1;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          // a bounce back high means the same physical press is still down
          if (key_valid) begin
            state_d = HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
      // start beats a digit landing on the same edge; that digit is dropped
      if (start_ok) begin
        load_d  = 1'b1;
        count_d = '0;
      end else if (accept) begin
        if (count_q == 3'd0) begin
          bcd_d   = {12'h000, code_q};
          count_d = 3'd1;
        end else if (count_q < 3'd4) begin
          bcd_d   = {bcd_q[11:0], code_q};
          count_d = count_q + 3'd1;
        end
      end
    end
  end

  assign bcd_time    = bcd_q;
  assign entry_count = count_q;
  assign time_load   = load_q;
  assign busy        = (state_q != IDLE);

endmodule
